life_grid_engine: RTL
=====================

Name: life_grid_engine

Overview:
- Parametrised Game-of-Life engine. Owns the full cell grid as one flat register, advances it one generation per accepted tick, and supports pause, run and single-step modes.
- Grid edges are selectable: edges read as dead, or the grid wraps as a torus.
- Fills the grid from a seeded LCG, clears it, or accepts single-cell writes.
- Sits between the generation clock divider and the VGA renderer; `upd_ok` (VGA vblank) gates grid updates so a frame never shows two generations.

Parameters:
- GRID_W, 32, columns; 3..32.
- GRID_H, 24, rows; ≥3.
- WRAP, 0, 0 = out-of-grid neighbours dead; 1 = toroidal wrap on both axes.
- SEED_INIT, 32'd7, LCG state loaded at reset.
- GEN_W, 16, width of the generation counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command strobe.
- cmd  in  3  0 PAUSE, 1 RUN, 2 STEP, 3 SEED, 4 CLEAR; 5-7 ignored.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- seed_in  in  32  loaded into LCG state when SEED is accepted.
- wr_en  in  1  single-cell write.
- wr_row  in  $clog2(GRID_H)  write row.
- wr_col  in  $clog2(GRID_W)  write column.
- wr_val  in  1  written state, 1 = alive.
- tick  in  1  one-cycle generation strobe.
- upd_ok  in  1  update window open (vblank).
- grid  out  GRID_W*GRID_H  cell (r,c) at bit r*GRID_W+c.
- gen_count  out  GEN_W  applied generations.
- running  out  1  high in RUN.
- busy  out  1  high in SEEDING.
- stable  out  1  last applied generation left the grid unchanged.
- extinct  out  1  grid all zero.
- overrun  out  1  sticky; a tick arrived while an update was pending.

Behaviour:
- Reset (edge with rst=1) values:
  - grid = 0, gen_count = 0.
  - State IDLE, pend = 0, stable = 0, overrun = 0.
  - LCG state = SEED_INIT.
  - cmd_ready = 1, running = 0, busy = 0.
  - extinct = 1 (combinational, registered grid == 0).
- Reset mid-SEEDING aborts the fill; reset wins over every other input.
- States: IDLE, RUN, SEEDING.
  - cmd_ready = (state != SEEDING).
  - Accepted commands:
    - PAUSE: → IDLE.
    - RUN: → RUN.
    - STEP: sets pend; state unchanged.
    - SEED: LCG state ← seed_in, row_idx ← 0, pend ← 0, → SEEDING.
    - CLEAR: grid ← 0, gen_count ← 0, pend ← 0, stable ← 0; state unchanged.
- SEEDING, one row per cycle:
  - Each cycle: s ← s*1664525 + 1013904223 (mod 2^32), then row row_idx ← s[GRID_W-1:0]; row_idx += 1.
  - After row GRID_H-1 is written: gen_count ← 0, stable ← 0, → IDLE.
  - Total duration is GRID_H cycles.
  - tick, wr_en and commands are ignored during SEEDING.
- Tick handling:
  - In RUN, tick sets pend at that edge; in IDLE/SEEDING, tick is ignored.
  - A tick (RUN) or accepted STEP arriving while pend = 1 sets overrun. overrun clears only on reset or CLEAR.
- Generation apply: on an edge where pend & upd_ok & state != SEEDING:
  - grid ← next(grid) for all cells simultaneously; pend ← 0.
  - gen_count += 1, saturating at all-ones.
  - stable ← (next == grid).
  - Earliest apply is the edge after the tick edge, so latency from tick to new grid is ≥1 cycle.
- next(grid): n = count of alive neighbours among 8. Alive survives if n ∈ {2,3}; dead is born if n == 3; all others dead.
  - WRAP=0: out-of-range neighbours count 0.
  - WRAP=1: indices are taken mod GRID_W / GRID_H.
- Cell write: wr_en in IDLE/RUN writes wr_val to (wr_row, wr_col) and clears stable.
  - Out-of-range indices are ignored.
  - If a generation applies on the same edge, the write is applied after it (write wins for that cell).
- Same-edge precedence: CLEAR beats both the generation apply and wr_en.

Test Plan:
- Reset then SEED with seed_in=7 (GRID_W=32) → busy for 24 cycles; row0 = 32'h3D20BDBA; gen_count = 0; IDLE after the fill.
- CLEAR, write a blinker at (5,4),(5,5),(5,6), STEP with upd_ok=1 → one cycle later cells (4,5),(5,5),(6,5) alive; gen_count = 1; stable = 0.
- Block (2x2) at the grid corner, WRAP=0, STEP → grid unchanged, stable = 1, gen_count = 1. Same block with WRAP=1 split across four corners → also stable.
- RUN, tick while upd_ok=0 for 10 cycles, second tick during that wait → no grid change until upd_ok rises, exactly one generation applied, overrun = 1.
- Glider in RUN, 4 applied ticks, WRAP=1 → glider shifted (+1,+1), gen_count = 4. Single cell, one STEP → extinct = 1.
- SEED issued, rst asserted on cycle 10 of the fill → grid = 0, state IDLE, cmd_ready = 1 on the next cycle.

Source files
------------

// File: rtl/life_grid_engine.sv
`default_nettype none
// ============================================================================
// Module      : life_grid_engine
// Description : Game-of-Life engine holding the whole cell grid in one flat
//               register. Advances one generation per accepted tick/STEP,
//               gated by the update window (vblank) so a frame never shows
//               two generations. Fills the grid from a seeded LCG, clears it,
//               or takes single-cell writes.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               cmd_valid/cmd/ready - PAUSE/RUN/STEP/SEED/CLEAR commands
//               seed_in             - LCG state loaded on SEED
//               wr_en/row/col/val   - single-cell write
//               tick, upd_ok        - generation strobe, update window
//               grid                - cell (r,c) at bit r*GRID_W+c
//               gen_count, running, busy, stable, extinct, overrun - status
// Revision    : 1.0 - initial release
// ============================================================================
module life_grid_engine #(
    parameter int          GRID_W    = 32,
    parameter int          GRID_H    = 24,
    parameter int          WRAP      = 0,
    parameter logic [31:0] SEED_INIT = 32'd7,
    parameter int          GEN_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    input  logic [2:0]                  cmd,
    output logic                        cmd_ready,
    input  logic [31:0]                 seed_in,
    input  logic                        wr_en,
    input  logic [$clog2(GRID_H)-1:0]   wr_row,
    input  logic [$clog2(GRID_W)-1:0]   wr_col,
    input  logic                        wr_val,
    input  logic                        tick,
    input  logic                        upd_ok,
    output logic [GRID_W*GRID_H-1:0]    grid,
    output logic [GEN_W-1:0]            gen_count,
    output logic                        running,
    output logic                        busy,
    output logic                        stable,
    output logic                        extinct,
    output logic                        overrun
);

    localparam int c_rw = $clog2(GRID_H);
    localparam int c_iw = $clog2(GRID_W*GRID_H);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_run     = 2'd1;
    localparam logic [1:0] c_st_seeding = 2'd2;

    localparam logic [2:0] c_cmd_pause = 3'd0;
    localparam logic [2:0] c_cmd_run   = 3'd1;
    localparam logic [2:0] c_cmd_step  = 3'd2;
    localparam logic [2:0] c_cmd_seed  = 3'd3;
    localparam logic [2:0] c_cmd_clear = 3'd4;

    localparam logic [c_rw-1:0] c_last_row = c_rw'(GRID_H-1);

    logic [1:0]               r_state;
    logic [GRID_W*GRID_H-1:0] r_grid;
    logic [GEN_W-1:0]         r_gen;
    logic                     r_pend;
    logic                     r_stable;
    logic                     r_overrun;
    logic [31:0]              r_lcg;
    logic [c_rw-1:0]          r_row_idx;

    logic [GRID_W*GRID_H-1:0] w_next;
    logic [31:0]              w_lcg_next;
    logic [c_iw-1:0]          w_row_base;
    logic [c_iw-1:0]          w_wr_idx;
    logic                     w_wr_in_range;
    logic                     w_cmd_acc;
    logic                     w_gen_req;

    assign w_lcg_next    = r_lcg * 32'd1664525 + 32'd1013904223;
    assign w_row_base    = c_iw'(int'(r_row_idx) * GRID_W);
    assign w_wr_idx      = c_iw'(int'(wr_row) * GRID_W + int'(wr_col));
    assign w_wr_in_range = (int'(wr_row) < GRID_H) && (int'(wr_col) < GRID_W);
    assign w_cmd_acc     = cmd_valid && cmd_ready;
    // A RUN tick and an accepted STEP both request one generation.
    assign w_gen_req     = (tick && (r_state == c_st_run)) ||
                           (w_cmd_acc && (cmd == c_cmd_step));

    // Next-generation logic: one neighbour counter per cell. Neighbour
    // indices are elaboration-time constants; in non-wrap mode the
    // off-grid neighbours are forced to zero.
    for (genvar r = 0; r < GRID_H; r++) begin : g_row
        for (genvar c = 0; c < GRID_W; c++) begin : g_col
            localparam int c_ru = (r == 0) ? GRID_H-1 : r-1;
            localparam int c_rd = (r == GRID_H-1) ? 0 : r+1;
            localparam int c_cl = (c == 0) ? GRID_W-1 : c-1;
            localparam int c_cr = (c == GRID_W-1) ? 0 : c+1;
            localparam bit c_vu = (WRAP != 0) || (r != 0);
            localparam bit c_vd = (WRAP != 0) || (r != GRID_H-1);
            localparam bit c_vl = (WRAP != 0) || (c != 0);
            localparam bit c_vr = (WRAP != 0) || (c != GRID_W-1);

            logic [7:0] w_nb;
            logic [3:0] w_cnt;

            assign w_nb[0] = (c_vu && c_vl) ? r_grid[c_ru*GRID_W + c_cl] : 1'b0;
            assign w_nb[1] =  c_vu          ? r_grid[c_ru*GRID_W + c]    : 1'b0;
            assign w_nb[2] = (c_vu && c_vr) ? r_grid[c_ru*GRID_W + c_cr] : 1'b0;
            assign w_nb[3] =  c_vl          ? r_grid[r*GRID_W + c_cl]    : 1'b0;
            assign w_nb[4] =  c_vr          ? r_grid[r*GRID_W + c_cr]    : 1'b0;
            assign w_nb[5] = (c_vd && c_vl) ? r_grid[c_rd*GRID_W + c_cl] : 1'b0;
            assign w_nb[6] =  c_vd          ? r_grid[c_rd*GRID_W + c]    : 1'b0;
            assign w_nb[7] = (c_vd && c_vr) ? r_grid[c_rd*GRID_W + c_cr] : 1'b0;

            assign w_cnt = 4'(w_nb[0]) + 4'(w_nb[1]) + 4'(w_nb[2]) + 4'(w_nb[3]) +
                           4'(w_nb[4]) + 4'(w_nb[5]) + 4'(w_nb[6]) + 4'(w_nb[7]);

            assign w_next[r*GRID_W + c] = (w_cnt == 4'd3) ||
                                          (r_grid[r*GRID_W + c] && (w_cnt == 4'd2));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_grid    <= '0;
            r_gen     <= '0;
            r_pend    <= 1'b0;
            r_stable  <= 1'b0;
            r_overrun <= 1'b0;
            r_lcg     <= SEED_INIT;
            r_row_idx <= '0;
        end else if (r_state == c_st_seeding) begin
            // Fill one row per cycle; everything else is ignored meanwhile.
            r_lcg                        <= w_lcg_next;
            r_grid[w_row_base +: GRID_W] <= w_lcg_next[GRID_W-1:0];
            if (r_row_idx == c_last_row) begin
                r_row_idx <= '0;
                r_gen     <= '0;
                r_stable  <= 1'b0;
                r_state   <= c_st_idle;
            end else begin
                r_row_idx <= r_row_idx + 1'b1;
            end
        end else begin
            // A request arriving while one is still pending is dropped and
            // flagged, so a late window never applies two generations.
            if (w_gen_req) begin
                if (r_pend) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_pend <= 1'b1;
                end
            end

            if (r_pend && upd_ok) begin
                r_grid   <= w_next;
                r_pend   <= 1'b0;
                r_stable <= (w_next == r_grid);
                if (r_gen != '1) begin
                    r_gen <= r_gen + 1'b1;
                end
            end

            // Placed after the generation update so the write wins its cell.
            if (wr_en && w_wr_in_range) begin
                r_grid[w_wr_idx] <= wr_val;
                r_stable         <= 1'b0;
            end

            // CLEAR is last so it overrides the generation and the write.
            if (w_cmd_acc) begin
                case (cmd)
                    c_cmd_pause: r_state <= c_st_idle;
                    c_cmd_run:   r_state <= c_st_run;
                    c_cmd_seed: begin
                        r_lcg     <= seed_in;
                        r_row_idx <= '0;
                        r_pend    <= 1'b0;
                        r_state   <= c_st_seeding;
                    end
                    c_cmd_clear: begin
                        r_grid    <= '0;
                        r_gen     <= '0;
                        r_pend    <= 1'b0;
                        r_stable  <= 1'b0;
                        r_overrun <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign grid      = r_grid;
    assign gen_count = r_gen;
    assign running   = (r_state == c_st_run);
    assign busy      = (r_state == c_st_seeding);
    assign cmd_ready = (r_state != c_st_seeding);
    assign stable    = r_stable;
    assign extinct   = (r_grid == '0);
    assign overrun   = r_overrun;

endmodule
`default_nettype wire
